uniq_set_serializer: RTL

UNIQ_SET_SERIALIZER -- requirements
Module: uniq_set_serializer

---
 rtl/uniq_pkg.sv | 12 +
 rtl/uniq_set_cmp.sv | 27 ++
 rtl/uniq_set_serializer.sv | 117 +++++++++++
 3 files changed

// File: rtl/uniq_pkg.sv
// Shared constants and FSM state type for the unique-value set serializer.
// Pure declarations: no logic, no latency, no flow control.
package uniq_pkg;
  localparam int UNIQ_DATA_W  = 8;
  localparam int UNIQ_N_SLOTS = 4;
  localparam int IDX_W        = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;
endpackage

// File: rtl/uniq_set_cmp.sv
// Flags a new set: slot 0 valid and any valid bit or valid slot value differs from the snapshot.
// Purely combinational, zero latency; no flow control of its own.
module uniq_set_cmp #(
  parameter int DATA_W  = 8,
  parameter int N_SLOTS = 4
) (
  input  logic [N_SLOTS-1:0][DATA_W-1:0] i_in_data,
  input  logic [N_SLOTS-1:0]             i_in_valid,
  input  logic [N_SLOTS-1:0][DATA_W-1:0] i_snap_data,
  input  logic [N_SLOTS-1:0]             i_snap_valid,
  output logic                           o_change
);
  logic w_diff;

  // Data in slots that are invalid on both sides is ignored.
  always_comb begin
    w_diff = 1'b0;
    for (int k = 0; k < N_SLOTS; k++) begin
      if ((i_in_valid[k] != i_snap_valid[k]) ||
          (i_in_valid[k] && (i_in_data[k] != i_snap_data[k]))) begin
        w_diff = 1'b1;
      end
    end
  end

  assign o_change = i_in_valid[0] & w_diff;
endmodule

// File: rtl/uniq_set_serializer.sv
// Emits each new set of unique values as one beat per valid slot; optional UNIQ_SER_COALESCE_CNT_EN adds coalesce_cnt.
// Latency: first beat valid one cycle after a set change is sampled; one IDLE cycle between sets.
// Backpressure: beats hold while m_ready=0; input sets arriving meanwhile are coalesced (latest wins).
module uniq_set_serializer
  import uniq_pkg::*;
#(
  parameter int DATA_W  = UNIQ_DATA_W,
  parameter int N_SLOTS = UNIQ_N_SLOTS
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  input  logic [DATA_W-1:0] in_3,
  input  logic              in_valid_0,
  input  logic              in_valid_1,
  input  logic              in_valid_2,
  input  logic              in_valid_3,
  output logic [DATA_W-1:0] m_data,
  output logic [IDX_W-1:0]  m_idx,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready
`ifdef UNIQ_SER_COALESCE_CNT_EN
  ,
  output logic [15:0]       coalesce_cnt
`endif
);
  logic [N_SLOTS-1:0][DATA_W-1:0] w_in_data;
  logic [N_SLOTS-1:0]             w_in_valid;
  logic [N_SLOTS-1:0][DATA_W-1:0] r_snap_data;
  logic [N_SLOTS-1:0]             r_snap_valid;
  state_t                         r_state;
  logic [IDX_W-1:0]               r_idx;
  logic [IDX_W-1:0]               w_next_idx;
  logic                           w_change;
  logic                           w_last;

  assign w_in_data  = {in_3, in_2, in_1, in_0};
  assign w_in_valid = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};

  uniq_set_cmp #(
    .DATA_W  (DATA_W),
    .N_SLOTS (N_SLOTS)
  ) u_cmp (
    .i_in_data    (w_in_data),
    .i_in_valid   (w_in_valid),
    .i_snap_data  (r_snap_data),
    .i_snap_valid (r_snap_valid),
    .o_change     (w_change)
  );

  // Valid bits are thermometer coded, so the beat is last when the next slot is empty.
  assign w_next_idx = r_idx + 1'b1;
  assign w_last     = (r_idx == IDX_W'(N_SLOTS - 1)) || !r_snap_valid[w_next_idx];

  assign m_valid = (r_state == SEND);
  assign m_data  = r_snap_data[r_idx];
  assign m_idx   = r_idx;
  assign m_last  = m_valid & w_last;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_snap_data  <= '0;
      r_snap_valid <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_change) begin
            r_snap_data  <= w_in_data;
            r_snap_valid <= w_in_valid;
            r_idx        <= '0;
            r_state      <= SEND;
          end
        end
        SEND: begin
          if (m_ready) begin
            if (w_last) begin
              r_state <= IDLE;
            end else begin
              r_idx <= w_next_idx;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef UNIQ_SER_COALESCE_CNT_EN
  logic [N_SLOTS-1:0][DATA_W-1:0] r_prev_data;
  logic [N_SLOTS-1:0]             r_prev_valid;
  logic [15:0]                    r_coalesce_cnt;

  // Any input movement while busy is a set that will never be emitted as such.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_prev_data    <= '0;
      r_prev_valid   <= '0;
      r_coalesce_cnt <= '0;
    end else begin
      r_prev_data  <= w_in_data;
      r_prev_valid <= w_in_valid;
      if ((r_state == SEND) &&
          ((w_in_data != r_prev_data) || (w_in_valid != r_prev_valid)) &&
          (r_coalesce_cnt != 16'hFFFF)) begin
        r_coalesce_cnt <= r_coalesce_cnt + 16'd1;
      end
    end
  end

  assign coalesce_cnt = r_coalesce_cnt;
`endif
endmodule
